// File: rtl/cpu_pkg.sv
// Shared types for the serial CPU core: sequencer states, opcodes, decoder bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          WORD_W  = 16;
  localparam logic [15:0] PC_STEP = 16'd2;  // byte-addressed, one 16-bit word

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    FETCH_IMM = 3'd2,
    EXEC      = 3'd3,
    MEM       = 3'd4,
    WB        = 3'd5,
    HALTED    = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    R_TYPE  = 3'd0,
    I_TYPE  = 3'd1,
    B_TYPE  = 3'd2,
    J_TYPE  = 3'd3,
    M_TYPE  = 3'd4,
    SYS_END = 3'd5
  } opcode_t;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic       double_word;
    logic       rf_write;
    logic       use_addr;
    logic       is_store;
    logic       halt;
  } dec_sig_t;

  // Encodings above SYS_END are unassigned; the sequencer neutralises them.
  function automatic logic op_known(input logic [2:0] op);
    return op <= 3'(SYS_END);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for serial shifters with enable, clear and terminal-count flag.
// Latency: count updates one cycle after en/clr; tc is combinational from count.
// Backpressure: none; holds its value while en is low.
// Ports: clock/reset (sync, active-high), en (advance), clr (return to 0, wins over en),
//        count (current bit index), tc (count is at LAST).
module serial_bit_counter #(
  parameter int CNT_W = 4,
  parameter int LAST  = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(LAST));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch (+imm), DATA_W-cycle serial exec, memory phase, writeback.
// Latency: (1+W) fetch + 1 decode [+ (1+W) imm] + DATA_W exec [+ (1+W) mem] + 1 wb.
// Backpressure: mem_req held until mem_ready; FSM stalls in the access state meanwhile.
// Ports: clock/reset (sync, active-high); mem_* single shared memory port;
//        ir/imm to the decoder; dec_* decoder results; alu_addr effective address;
//        branch_taken/target_pc redirect in WB; alu_shift_en/bit_idx drive the serial ALU;
//        rf_write_en register-file strobe; pc program counter; halted stop flag.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = $clog2(DATA_W)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [15:0]      ir,
  output logic [15:0]      imm,
  input  logic [2:0]       dec_opcode,
  input  logic             dec_double,
  input  logic             dec_rf_write,
  input  logic             dec_use_addr,
  input  logic             dec_is_store,
  input  logic             dec_halt,
  input  logic [15:0]      alu_addr,
  input  logic             branch_taken,
  input  logic [15:0]      target_pc,
  output logic             alu_shift_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic             rf_write_en,
  output logic [15:0]      pc,
  output logic             halted
);

  seq_state_t state, state_nxt;
  dec_sig_t   dec;
  logic       known_op;
  logic       cnt_en, cnt_clr, cnt_tc;

  assign dec = '{
    opcode:      dec_opcode,
    double_word: dec_double,
    rf_write:    dec_rf_write,
    use_addr:    dec_use_addr,
    is_store:    dec_is_store,
    halt:        dec_halt
  };
  assign known_op = op_known(dec.opcode);

  serial_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (DATA_W - 1)
  ) u_bit_cnt (
    .clock (clock),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (bit_idx),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      imm   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + PC_STEP;
          end
        end
        FETCH_IMM: begin
          if (mem_ready) begin
            imm <= mem_rdata;
            pc  <= pc + PC_STEP;
          end
        end
        WB: begin
          // Redirect overrides the sequential pc already advanced during fetch.
          if (branch_taken) begin
            pc <= target_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = pc;
    alu_shift_en = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    rf_write_en  = 1'b0;
    halted       = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        if (dec.halt)             state_nxt = HALTED;
        else if (dec.double_word) state_nxt = FETCH_IMM;
        else                      state_nxt = EXEC;
      end
      FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = EXEC;
      end
      EXEC: begin
        alu_shift_en = 1'b1;
        cnt_en       = 1'b1;
        if (cnt_tc) begin
          cnt_clr   = 1'b1;
          // Unassigned opcodes never enter the memory phase.
          state_nxt = (dec.use_addr && known_op) ? MEM : WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_addr;
        mem_we   = dec.is_store;
        if (mem_ready) state_nxt = WB;
      end
      WB: begin
        rf_write_en = dec.rf_write && known_op;
        state_nxt   = FETCH;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase

    // While reset is held the core is silent, even though the state register
    // only returns to FETCH at the next edge.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      alu_shift_en = 1'b0;
      cnt_en       = 1'b0;
      rf_write_en  = 1'b0;
      halted       = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_rdata, ir, imm, alu_addr, target_pc, pc;
  logic [2:0]  dec_opcode;
  logic        dec_double, dec_rf_write, dec_use_addr, dec_is_store, dec_halt;
  logic        branch_taken, alu_shift_en, rf_write_en, halted;
  logic [3:0]  bit_idx;

  always #5 clock = ~clock;

  cpu_sequencer #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir(ir), .imm(imm),
    .dec_opcode(dec_opcode), .dec_double(dec_double), .dec_rf_write(dec_rf_write),
    .dec_use_addr(dec_use_addr), .dec_is_store(dec_is_store), .dec_halt(dec_halt),
    .alu_addr(alu_addr), .branch_taken(branch_taken), .target_pc(target_pc),
    .alu_shift_en(alu_shift_en), .bit_idx(bit_idx), .rf_write_en(rf_write_en),
    .pc(pc), .halted(halted)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
  } acc_t;

  acc_t        exp_q[$];
  logic [15:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;
  int          wait_cfg, wcnt, req_run, cyc, sh_cnt, wb_cnt, wb_cyc, halt_cnt, req_cnt;
  logic [3:0]  exp_bit;
  logic        take;
  logic [15:0] target;

  // Decoder model: bit 12 of an M_TYPE word selects store.
  always_comb begin
    dec_opcode   = ir[15:13];
    dec_double   = (ir[15:13] == I_TYPE) || (ir[15:13] == M_TYPE);
    dec_use_addr = (ir[15:13] == M_TYPE);
    dec_is_store = (ir[15:13] == M_TYPE) && ir[12];
    dec_rf_write = (ir[15:13] == R_TYPE) || (ir[15:13] == I_TYPE) ||
                   (ir[15:13] == J_TYPE) || ((ir[15:13] == M_TYPE) && !ir[12]);
    dec_halt     = (ir[15:13] == SYS_END);
    branch_taken = ((ir[15:13] == B_TYPE) || (ir[15:13] == J_TYPE)) && take;
    target_pc    = target;
  end

  function automatic logic [15:0] word(input opcode_t op, input logic [12:0] rest);
    return {op, rest};
  endfunction

  task automatic push(input logic [15:0] a, input logic w);
    acc_t e;
    e.addr = a;
    e.we   = w;
    exp_q.push_back(e);
  endtask

  // One clock cycle: act as the memory, score completed accesses, then advance.
  task automatic step();
    acc_t e;
    mem_ready = mem_req && (wcnt == wait_cfg);
    mem_rdata = mem_ready ? mem[mem_addr[8:1]] : 16'hDEAD;
    #1;
    cyc++;
    if (mem_req) begin
      req_cnt++;
      req_run++;
    end else begin
      req_run = 0;
    end
    if (mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access cyc=%0d got addr=%h we=%b, expected no access",
                 cyc, mem_addr, mem_we);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_we !== e.we || req_run != wait_cfg + 1) begin
          errors++;
          $display("FAIL access cyc=%0d got addr=%h we=%b req_cycles=%0d, expected addr=%h we=%b req_cycles=%0d",
                   cyc, mem_addr, mem_we, req_run, e.addr, e.we, wait_cfg + 1);
        end
      end
      wcnt    = 0;
      req_run = 0;
    end else if (mem_req) begin
      wcnt++;
    end
    if (alu_shift_en) begin
      sh_cnt++;
      checks++;
      if (bit_idx !== exp_bit || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL exec_bit cyc=%0d got bit_idx=%0d mem_req=%b, expected bit_idx=%0d mem_req=0",
                 cyc, bit_idx, mem_req, exp_bit);
      end
      exp_bit++;
    end
    if (rf_write_en) begin
      wb_cnt++;
      wb_cyc = cyc;
    end
    if (halted) halt_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    wcnt = 0; req_run = 0; cyc = 0; sh_cnt = 0; wb_cnt = 0; wb_cyc = 0;
    halt_cnt = 0; req_cnt = 0; exp_bit = 4'd0;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    clear_model();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;          // must be ignored while in reset
    mem_rdata = 16'hFFFF;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if ({pc, ir, imm, bit_idx} !== 52'h0) begin
      errors++;
      $display("FAIL reset_regs got pc=%h ir=%h imm=%h bit_idx=%0d, expected all zero", pc, ir, imm, bit_idx);
    end
    checks++;
    if ({mem_req, mem_we, alu_shift_en, rf_write_en, halted} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got req=%b we=%b shift=%b rfw=%b halted=%b, expected all 0",
               mem_req, mem_we, alu_shift_en, rf_write_en, halted);
    end
    clear_model();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_fetch got req=%b addr=%h we=%b, expected req=1 addr=0000 we=0",
               mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_r_type();
    do_reset();
    wait_cfg = 0; take = 1'b0;
    mem[0] = word(R_TYPE, 13'h0123);
    push(16'h0000, 1'b0);
    push(16'h0002, 1'b0);
    repeat (20) step();
    checks++;
    if (sh_cnt != 16) begin
      errors++;
      $display("FAIL r_shift_cycles got=%0d expected=16", sh_cnt);
    end
    checks++;
    if (wb_cnt != 1 || wb_cyc != 19) begin
      errors++;
      $display("FAIL r_rf_write got count=%0d cycle=%0d, expected count=1 cycle=19", wb_cnt, wb_cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL r_pending got=%0d accesses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_i_type_waits();
    do_reset();
    wait_cfg = 3; take = 1'b0;
    mem[0] = word(I_TYPE, 13'h0042);
    mem[1] = 16'hBEEF;
    push(16'h0000, 1'b0);
    push(16'h0002, 1'b0);
    push(16'h0004, 1'b0);
    repeat (26) step();
    checks++;
    if (imm !== 16'hBEEF || ir !== word(I_TYPE, 13'h0042)) begin
      errors++;
      $display("FAIL i_capture got ir=%h imm=%h, expected ir=%h imm=beef", ir, imm, word(I_TYPE, 13'h0042));
    end
    checks++;
    if (pc !== 16'h0004 || mem_req !== 1'b1 || mem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL i_next_fetch got pc=%h req=%b addr=%h, expected pc=0004 req=1 addr=0004", pc, mem_req, mem_addr);
    end
    checks++;
    if (wb_cnt != 1 || wb_cyc != 26) begin
      errors++;
      $display("FAIL i_rf_write got count=%0d cycle=%0d, expected count=1 cycle=26", wb_cnt, wb_cyc);
    end
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL i_pending got=%0d accesses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_m_store();
    do_reset();
    wait_cfg = 0; take = 1'b0;
    alu_addr = 16'h1234;
    mem[0] = word(M_TYPE, 13'h1000);
    mem[1] = 16'h0010;
    push(16'h0000, 1'b0);
    push(16'h0002, 1'b0);
    push(16'h1234, 1'b1);
    push(16'h0004, 1'b0);
    repeat (22) step();
    checks++;
    if (wb_cnt != 0) begin
      errors++;
      $display("FAIL store_rf_write got=%0d pulses, expected 0", wb_cnt);
    end
    checks++;
    if (exp_q.size() != 0 || sh_cnt != 16) begin
      errors++;
      $display("FAIL store_sequence got outstanding=%0d shifts=%0d, expected 0 and 16", exp_q.size(), sh_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    wait_cfg = 0; take = 1'b1; target = 16'h0040;
    mem[0] = word(B_TYPE, 13'h0007);
    push(16'h0000, 1'b0);
    push(16'h0040, 1'b0);
    repeat (20) step();
    checks++;
    if (exp_q.size() != 0 || pc !== 16'h0042 || wb_cnt != 0) begin
      errors++;
      $display("FAIL branch_taken got outstanding=%0d pc=%h rfw=%0d, expected 0 0042 0", exp_q.size(), pc, wb_cnt);
    end
    do_reset();
    take = 1'b0;
    mem[0] = word(B_TYPE, 13'h0007);
    push(16'h0000, 1'b0);
    push(16'h0002, 1'b0);
    repeat (20) step();
    checks++;
    if (exp_q.size() != 0 || pc !== 16'h0004) begin
      errors++;
      $display("FAIL branch_not_taken got outstanding=%0d pc=%h, expected 0 0004", exp_q.size(), pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    wait_cfg = 0; take = 1'b0;
    mem[0] = word(SYS_END, 13'h0000);
    push(16'h0000, 1'b0);
    step();
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_decode got halted=%b in decode cycle, expected 0", halted);
    end
    step();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_assert got halted=%b after decode, expected 1", halted);
    end
    repeat (50) step();
    checks++;
    if (halt_cnt != 50 || req_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL halt_sticky got halted_cycles=%0d req_cycles=%0d outstanding=%0d, expected 50 1 0",
               halt_cnt, req_cnt, exp_q.size());
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || pc !== 16'h0000 || mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL halt_reset got halted=%b pc=%h req=%b addr=%h, expected 0 0000 1 0000",
               halted, pc, mem_req, mem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    wait_cfg = 0; take = 1'b1; target = 16'hFFFE;
    mem[0]     = word(J_TYPE, 13'h0001);
    mem[8'hFF] = word(R_TYPE, 13'h0002);
    push(16'h0000, 1'b0);
    push(16'hFFFE, 1'b0);
    push(16'h0000, 1'b0);
    repeat (38) step();
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_pc got=%h expected=0000", pc);
    end
    step();
    checks++;
    if (pc !== 16'h0002 || exp_q.size() != 0 || wb_cnt != 2) begin
      errors++;
      $display("FAIL wrap_fetch got pc=%h outstanding=%0d rfw=%0d, expected 0002 0 2", pc, exp_q.size(), wb_cnt);
    end
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    wait_cfg = 3; take = 1'b0;
    alu_addr = 16'h1234;
    mem[0] = word(M_TYPE, 13'h0000);
    mem[1] = 16'h0004;
    push(16'h0000, 1'b0);
    push(16'h0002, 1'b0);
    repeat (26) step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL load_mem_wait got req=%b addr=%h we=%b, expected 1 1234 0", mem_req, mem_addr, mem_we);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hFFFF;
    @(posedge clock);
    #1;
    checks++;
    if (mem_req !== 1'b0 || {pc, ir, imm, bit_idx} !== 52'h0) begin
      errors++;
      $display("FAIL mem_reset got req=%b pc=%h ir=%h imm=%h, expected req=0 and zeros", mem_req, pc, ir, imm);
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || mem_we !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mem_reset_fetch got req=%b addr=%h we=%b outstanding=%0d, expected 1 0000 0 0",
               mem_req, mem_addr, mem_we, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    take = 1'b0;
    target = 16'h0000;
    alu_addr = 16'h0000;
    wait_cfg = 0;
    clear_model();
    test_reset();
    test_r_type();
    test_i_type_waits();
    test_m_store();
    test_branch();
    test_halt();
    test_pc_wrap();
    test_reset_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
